// File: rtl/sprite_fetch_pipe.sv
// Two-stage sprite ROM address pipeline: per-channel hit test, then fixed-priority select.
// Define SPRITE_MIRROR_EN to build per-channel horizontal flip; otherwise mirror_in is ignored.
module sprite_fetch_pipe #(
  parameter int HWIDTH = 10,
  parameter int VWIDTH = 10,
  parameter int IWIDTH = 1,
  parameter int HSIZE  = 64,
  parameter int VSIZE  = 64,
  parameter int NSPR   = 4,
  parameter int AWIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      pix_valid_in,
  input  logic [HWIDTH-1:0]         hdata,
  input  logic [VWIDTH-1:0]         vdata,
  input  logic [NSPR*HWIDTH-1:0]    hoffset_in,
  input  logic [NSPR*VWIDTH-1:0]    voffset_in,
  input  logic [NSPR-1:0]           enable_in,
  input  logic [NSPR-1:0]           mirror_in,
  output logic [AWIDTH-1:0]         addr,
  output logic [$clog2(NSPR)-1:0]   sel,
  output logic                      hit,
  output logic                      pix_valid_out
);

  localparam int unsigned COLS = HSIZE >> IWIDTH;
  localparam int unsigned ROWS = VSIZE >> IWIDTH;
  localparam int SELW = $clog2(NSPR);
  localparam logic [HWIDTH-1:0] HSIZE_W = HWIDTH'(HSIZE);
  localparam logic [VWIDTH-1:0] VSIZE_W = VWIDTH'(VSIZE);

  if (longint'(NSPR) * longint'(COLS) * longint'(ROWS) > (longint'(1) << AWIDTH)) begin : g_bad_awidth
    $error("sprite_fetch_pipe: NSPR*COLS*ROWS exceeds ROM address space");
  end
  if ((longint'(HSIZE) >= (longint'(1) << (HWIDTH-1))) ||
      (longint'(VSIZE) >= (longint'(1) << (VWIDTH-1)))) begin : g_bad_size
    $error("sprite_fetch_pipe: sprite size must be below half the coordinate range");
  end

  // Shadow copies of per-frame sprite state
  logic [NSPR*HWIDTH-1:0] hoff_sh;
  logic [NSPR*VWIDTH-1:0] voff_sh;
  logic [NSPR-1:0]        en_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hoff_sh <= '0;
      voff_sh <= '0;
      en_sh   <= '0;
    end else if (frame_start) begin
      hoff_sh <= hoffset_in;
      voff_sh <= voffset_in;
      en_sh   <= enable_in;
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic [NSPR-1:0] mir_sh;
  logic [NSPR-1:0] mir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              mir_sh <= '0;
    else if (frame_start) mir_sh <= mirror_in;
  end

  // Flip flag travels with the pixel so a same-cycle shadow reload cannot affect it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mir_q <= '0;
    else     mir_q <= mir_sh;
  end
`else
  logic unused_mirror;
  assign unused_mirror = ^mirror_in;
`endif

  // Stage 1: per-channel relative coordinates and coverage
  logic [HWIDTH-1:0] h_diff [NSPR];
  logic [VWIDTH-1:0] v_diff [NSPR];
  logic [NSPR-1:0]   in_d;
  logic [HWIDTH-1:0] h_q [NSPR];
  logic [VWIDTH-1:0] v_q [NSPR];
  logic [NSPR-1:0]   in_q;
  logic              valid_q;

  always_comb begin
    in_d = '0;
    for (int unsigned i = 0; i < NSPR; i++) begin
      h_diff[i] = hdata - hoff_sh[i*HWIDTH +: HWIDTH];
      v_diff[i] = vdata - voff_sh[i*VWIDTH +: VWIDTH];
      in_d[i]   = en_sh[i] && (h_diff[i] < HSIZE_W) && (v_diff[i] < VSIZE_W);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSPR; i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      in_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NSPR; i++) begin
        h_q[i] <= h_diff[i];
        v_q[i] <= v_diff[i];
      end
      in_q    <= in_d;
      valid_q <= pix_valid_in;
    end
  end

  // Stage 2: lowest-index covering channel wins
  logic            found;
  logic [SELW-1:0] win;
  logic [31:0]     col_w;
  logic [31:0]     row_w;
  logic [31:0]     addr_w;
  logic            hit_d;
  logic [SELW-1:0] sel_d;
  logic [AWIDTH-1:0] addr_d;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NSPR; i++) begin
      if (in_q[i] && !found) begin
        found = 1'b1;
        win   = i[SELW-1:0];
      end
    end

    col_w = 32'(h_q[win] >> IWIDTH);
    row_w = 32'(v_q[win] >> IWIDTH);
`ifdef SPRITE_MIRROR_EN
    if (mir_q[win]) col_w = 32'(COLS - 1) - col_w;
`endif
    addr_w = 32'(win) * 32'(COLS * ROWS) + row_w * 32'(COLS) + col_w;

    hit_d  = 1'b0;
    sel_d  = '0;
    addr_d = '0;
    if (found && valid_q) begin
      hit_d  = 1'b1;
      sel_d  = win;
      addr_d = addr_w[AWIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      sel           <= '0;
      hit           <= 1'b0;
      pix_valid_out <= 1'b0;
    end else begin
      addr          <= addr_d;
      sel           <= sel_d;
      hit           <= hit_d;
      pix_valid_out <= valid_q;
    end
  end

endmodule
